// File: rtl/fpu_add_ctrl_pkg.sv
// Shared constants for the FP adder phase controller:
// state codes and end-to-end latencies.
package fpu_add_ctrl_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [ST_W-1:0] ST_LOAD_OPS = 4'd1;
    localparam logic [ST_W-1:0] ST_EXP_CMP  = 4'd2;
    localparam logic [ST_W-1:0] ST_ALIGN    = 4'd3;
    localparam logic [ST_W-1:0] ST_ADD      = 4'd4;
    localparam logic [ST_W-1:0] ST_NORM     = 4'd5;
    localparam logic [ST_W-1:0] ST_ROUND_A  = 4'd6;
    localparam logic [ST_W-1:0] ST_ROUND_B  = 4'd7;
    localparam logic [ST_W-1:0] ST_CHECK    = 4'd8;
    localparam logic [ST_W-1:0] ST_RENORM   = 4'd9;
    localparam logic [ST_W-1:0] ST_FINAL    = 4'd10;
    localparam logic [ST_W-1:0] ST_DONE     = 4'd11;

    localparam int LAT_NORMAL = 10;
    localparam int LAT_RENORM = 11;
    localparam int LAT_ZERO   = 6;

    typedef enum logic [ST_W-1:0] {
        IDLE     = ST_IDLE,
        LOAD_OPS = ST_LOAD_OPS,
        EXP_CMP  = ST_EXP_CMP,
        ALIGN    = ST_ALIGN,
        ADD      = ST_ADD,
        NORM     = ST_NORM,
        ROUND_A  = ST_ROUND_A,
        ROUND_B  = ST_ROUND_B,
        CHECK    = ST_CHECK,
        RENORM   = ST_RENORM,
        FINAL    = ST_FINAL,
        DONE     = ST_DONE
    } state_t;

endpackage

// File: rtl/fpu_add_phase_ctrl.sv
// Moore sequencer for the FP add/sub datapath phases.
// Strobes are registered from the next state so they are glitch-free.
module fpu_add_phase_ctrl
    import fpu_add_ctrl_pkg::*;
#(
    parameter bit EN_ZERO_SKIP = 1'b1,
    parameter bit EN_RENORM    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic beg_fsm,
    input  logic ack_fsm,
    input  logic zero_res_i,
    input  logic round_ovf_i,
    output logic load_op_o,
    output logic load_exp_o,
    output logic load_shft_o,
    output logic load_add_o,
    output logic load_norm_o,
    output logic ctrl_a_o,
    output logic ctrl_b_o,
    output logic shft_r_o,
    output logic load_final_o,
    output logic zero_sel_o,
    output logic busy_o,
    output logic ready_o
);

    state_t state;
    state_t nxt;
    logic   skip;

    assign skip = EN_ZERO_SKIP && zero_res_i;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (beg_fsm) nxt = LOAD_OPS;
            LOAD_OPS: nxt = EXP_CMP;
            EXP_CMP:  nxt = ALIGN;
            ALIGN:    nxt = ADD;
            ADD:      nxt = skip ? FINAL : NORM;
            NORM:     nxt = ROUND_A;
            ROUND_A:  nxt = ROUND_B;
            ROUND_B:  nxt = CHECK;
            CHECK: begin
                if (EN_RENORM && round_ovf_i) nxt = RENORM;
                else                          nxt = FINAL;
            end
            RENORM:   nxt = FINAL;
            FINAL:    nxt = DONE;
            DONE:     if (ack_fsm) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            load_op_o    <= 1'b0;
            load_exp_o   <= 1'b0;
            load_shft_o  <= 1'b0;
            load_add_o   <= 1'b0;
            load_norm_o  <= 1'b0;
            ctrl_a_o     <= 1'b0;
            ctrl_b_o     <= 1'b0;
            shft_r_o     <= 1'b0;
            load_final_o <= 1'b0;
            zero_sel_o   <= 1'b0;
            busy_o       <= 1'b0;
            ready_o      <= 1'b0;
        end else begin
            state        <= nxt;
            load_op_o    <= (nxt == LOAD_OPS);
            load_exp_o   <= (nxt == EXP_CMP);
            load_shft_o  <= (nxt == ALIGN);
            load_add_o   <= (nxt == ADD);
            load_norm_o  <= (nxt == NORM);
            ctrl_a_o     <= (nxt == ROUND_A);
            ctrl_b_o     <= (nxt == ROUND_B);
            shft_r_o     <= (nxt == RENORM);
            load_final_o <= (nxt == FINAL);
            busy_o       <= (nxt != IDLE);
            ready_o      <= (nxt == DONE);
            // Zero flag lives from the skip edge until the op retires.
            if (nxt == IDLE)
                zero_sel_o <= 1'b0;
            else if (state == ADD && nxt == FINAL)
                zero_sel_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpu_add_phase_ctrl.sv
// Bench for fpu_add_phase_ctrl: timeline reference model for two
// parameterisations plus directed handshake and reset scenarios.
module tb_fpu_add_phase_ctrl;
    import fpu_add_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic beg = 1'b0;
    logic ack = 1'b0;
    logic zres = 1'b0;
    logic ovf = 1'b0;

    // bit order: op exp shft add norm ca cb shr fin zsel busy ready
    wire [11:0] va;
    wire [11:0] vb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fpu_add_phase_ctrl dut_a (
        .clk(clk), .rst(rst), .beg_fsm(beg), .ack_fsm(ack),
        .zero_res_i(zres), .round_ovf_i(ovf),
        .load_op_o(va[11]), .load_exp_o(va[10]),
        .load_shft_o(va[9]), .load_add_o(va[8]),
        .load_norm_o(va[7]), .ctrl_a_o(va[6]),
        .ctrl_b_o(va[5]), .shft_r_o(va[4]),
        .load_final_o(va[3]), .zero_sel_o(va[2]),
        .busy_o(va[1]), .ready_o(va[0])
    );

    fpu_add_phase_ctrl #(
        .EN_ZERO_SKIP(1'b0),
        .EN_RENORM(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .beg_fsm(beg), .ack_fsm(ack),
        .zero_res_i(zres), .round_ovf_i(ovf),
        .load_op_o(vb[11]), .load_exp_o(vb[10]),
        .load_shft_o(vb[9]), .load_add_o(vb[8]),
        .load_norm_o(vb[7]), .ctrl_a_o(vb[6]),
        .ctrl_b_o(vb[5]), .shft_r_o(vb[4]),
        .load_final_o(vb[3]), .zero_sel_o(vb[2]),
        .busy_o(vb[1]), .ready_o(vb[0])
    );

    task automatic chk(input string nm, input logic [11:0] got,
                       input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", nm, got, want, $time);
        end
    endtask

    // Model: cycles elapsed since the start edge, plus the two
    // path decisions taken at the ADD and CHECK points.
    int t [2];
    bit z [2];
    bit r [2];
    bit p_skip [2];
    bit p_ren [2];

    initial begin
        p_skip[0] = 1'b1; p_ren[0] = 1'b1;
        p_skip[1] = 1'b0; p_ren[1] = 1'b0;
    end

    function automatic int lat_of(bit zz, bit rr);
        if (zz) return LAT_ZERO;
        if (rr) return LAT_RENORM;
        return LAT_NORMAL;
    endfunction

    function automatic logic [11:0] expect_vec(int tt, bit zz, bit rr);
        logic [11:0] v;
        if (tt == 0) return 12'h000;
        v = 12'h002;
        v[2] = zz;
        if (tt >= lat_of(zz, rr)) begin
            v[0] = 1'b1;
            return v;
        end
        case (tt)
            1: v[11] = 1'b1;
            2: v[10] = 1'b1;
            3: v[9] = 1'b1;
            4: v[8] = 1'b1;
            5: if (zz) v[3] = 1'b1; else v[7] = 1'b1;
            6: v[6] = 1'b1;
            7: v[5] = 1'b1;
            9: if (rr) v[4] = 1'b1; else v[3] = 1'b1;
            10: v[3] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                t[i] <= 0; z[i] <= 1'b0; r[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (t[i] == 0) begin
                    if (beg) begin
                        t[i] <= 1; z[i] <= 1'b0; r[i] <= 1'b0;
                    end
                end else if (t[i] >= lat_of(z[i], r[i])) begin
                    if (ack) t[i] <= 0;
                end else begin
                    if (t[i] == 4) z[i] <= p_skip[i] && zres;
                    if (t[i] == 8) r[i] <= p_ren[i] && ovf;
                    t[i] <= t[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_a", va, expect_vec(t[0], z[0], r[0]));
        chk("model_b", vb, expect_vec(t[1], z[1], r[1]));
    end

    // One op from IDLE; hand-computed milestones checked afterwards.
    task automatic run_op(input bit zr, input bit ov, input int ack_cyc,
                          input bit ack_early, input int rdy_a_exp,
                          input int rdy_b_exp, input int shr_a_exp,
                          input int zs_a_exp);
        int rdy_a = 0;
        int rdy_b = 0;
        int shr_a = 0;
        int zs_a = 0;
        @(posedge clk); #2;
        beg = 1'b1; zres = zr; ovf = ov;
        @(posedge clk); #2;
        beg = 1'b0;
        for (int c = 1; c <= ack_cyc + 1; c++) begin
            ack = (c == ack_cyc) || (ack_early && c <= 9);
            @(negedge clk);
            if (va[0] && rdy_a == 0) rdy_a = c;
            if (vb[0] && rdy_b == 0) rdy_b = c;
            if (va[4]) shr_a++;
            if (va[2]) zs_a++;
            if (c == 1) chk("load_op_c1", {11'd0, va[11]}, 12'd1);
            if (c == ack_cyc + 1) chk("idle_after_ack", {11'd0, va[1]}, 12'd0);
            @(posedge clk); #2;
        end
        ack = 1'b0;
        chk("ready_cycle_a", rdy_a[11:0], rdy_a_exp[11:0]);
        chk("ready_cycle_b", rdy_b[11:0], rdy_b_exp[11:0]);
        chk("shft_r_count", shr_a[11:0], shr_a_exp[11:0]);
        chk("zero_sel_cycles", zs_a[11:0], zs_a_exp[11:0]);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (20) @(posedge clk);
        #2;

        run_op(1'b0, 1'b0, 12, 1'b0, 10, 10, 0, 0);
        run_op(1'b0, 1'b1, 12, 1'b0, 11, 10, 1, 0);
        run_op(1'b1, 1'b0, 12, 1'b0, 6, 10, 0, 8);
        run_op(1'b0, 1'b0, 12, 1'b1, 10, 10, 0, 0);

        // beg and ack both held: DONE -> IDLE, then a fresh start.
        @(posedge clk); #2;
        beg = 1'b1; ack = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("held_idle_c11", {11'd0, va[1]}, 12'd0);
        @(negedge clk);
        chk("held_restart_c12", {11'd0, va[11]}, 12'd1);
        #2 beg = 1'b0;
        repeat (12) @(posedge clk);
        #2 ack = 1'b0;

        // Abort in ROUND_A.
        @(posedge clk); #2 beg = 1'b1;
        @(posedge clk); #2 beg = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("ctrl_a_before_rst", {11'd0, va[6]}, 12'd1);
        rst = 1'b0;
        #1;
        chk("ctrl_a_async_drop", va, 12'd0);
        chk("dut_b_async_drop", vb, 12'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        repeat (10) @(posedge clk);
        #2;

        repeat (4000) begin
            beg = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) == 0);
            zres = $urandom_range(0, 1) == 1;
            ovf = $urandom_range(0, 1) == 1;
            rst = !($urandom_range(0, 249) == 0);
            @(posedge clk); #2;
        end
        rst = 1'b1; beg = 1'b0; ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
